mm_job_ctrl: RTL and testbench
==============================

Name: mm_job_ctrl

Overview:
Job sequencer that drives one custom_matmul16x16 instance through a full job.
- Streams operand words from a valid/ready input into the IP SRAM, then starts the multiply and waits for done.
- Reads the result region back out on a valid/ready output stream.
- Sits between the SoC-side host/DMA streams and the matmul IP, and owns all of the IP's memory, control and reset pins.

Parameters:
LD_BASE, 0, first SRAM word address written during load (A then B, contiguous)
LD_WORDS, 128, operand words written per job
RD_BASE, 128, first SRAM word address of result region
RD_WORDS, 256, result words read per job
TIMEOUT_CYCLES, 4096, max cycles in RUN before abort

Ports:
i_clk  input  1  clock
i_rstn  input  1  synchronous active-low reset
i_start  input  1  job start pulse; accepted only when o_busy=0
i_fl  input  3  fractional-length config, latched on accepted start
o_busy  output  1  high from accepted start until job end or abort
o_err  output  1  sticky timeout flag, cleared on next accepted start
i_in_valid  input  1  operand word valid
o_in_ready  output  1  operand word ready
i_in_data  input  32  operand word
o_out_valid  output  1  result word valid
i_out_ready  input  1  result word ready
o_out_data  output  32  result word
o_out_last  output  1  marks final result word (RD_WORDS-th)
o_mm_cen  output  1  IP SRAM chip enable, active-low
o_mm_wen  output  1  IP SRAM write enable, active-low
o_mm_addr  output  9  IP SRAM word address
o_mm_din  output  32  IP SRAM write data
i_mm_dout  input  32  IP SRAM read data, valid 1 cycle after read access
o_mm_rstn  output  1  IP reset, active-low
o_mm_matmul_en  output  1  IP run enable
o_mm_fl  output  3  IP fractional-length config
i_mm_done  input  1  IP completion level

Behaviour:
- Clock i_clk; reset synchronous active-low on i_rstn.
- Reset values:
  - o_mm_cen=1, o_mm_wen=1; o_mm_addr, o_mm_din, o_mm_fl all 0.
  - o_mm_matmul_en=0, o_mm_rstn=0.
  - o_in_ready=0, o_out_valid=0, o_out_last=0, o_busy=0, o_err=0.
  - FSM=IDLE.
- o_mm_rstn is registered: it goes 1 the first cycle after i_rstn=1 is sampled. It is also forced 0 for 2 cycles on abort.
- All o_mm_* outputs are registered.
- IDLE:
  - i_start=1 -> latch i_fl into o_mm_fl, clear o_err, set o_busy, clear word counter, go LOAD.
  - i_start is ignored while o_busy=1.
- LOAD:
  - o_in_ready=1.
  - Each handshake (valid&ready) registers cen=0, wen=0, addr=LD_BASE+idx, din=i_in_data for exactly 1 cycle. SRAM write occurs the cycle after the handshake.
  - No handshake -> cen=1, wen=1 that cycle.
  - After the LD_WORDS-th handshake, o_in_ready drops the next cycle; go RUN.
- RUN:
  - o_mm_matmul_en=1; cen=1.
  - Cycle counter starts at 0.
  - i_mm_done=1 sampled -> matmul_en=0 next cycle; go UNLOAD.
  - Counter reaching TIMEOUT_CYCLES-1 without done -> ABORT.
- UNLOAD:
  - Issues reads cen=0, wen=1, addr=RD_BASE+ridx.
  - Data captured 1 cycle later into a 2-entry output FIFO.
  - A read issues only when FIFO occupancy + reads in flight < 2, so there is no overflow under any i_out_ready pattern.
  - With i_out_ready held 1: one word per cycle after a 2-cycle initial latency (first read at UNLOAD entry, o_out_valid 2 cycles later).
  - o_out_valid/o_out_data/o_out_last hold stable while o_out_valid=1 and i_out_ready=0.
  - o_out_last=1 only with the RD_WORDS-th word.
  - After the handshake of the last word -> o_busy=0 the next cycle, go IDLE.
- ABORT (1 pass):
  - matmul_en=0, o_mm_rstn=0 for 2 cycles, o_err=1, o_busy=0, go IDLE.
  - No output words are produced for an aborted job.
- Address arithmetic is 9-bit, wrapping mod 512. LD_BASE+LD_WORDS and RD_BASE+RD_WORDS must each be ≤512; this is a parameter legality rule checked by an elaboration-time assertion.
- Reset mid-job: all state returns to reset values on the next edge. FIFO contents and partial loads are discarded; the IP is held in reset via o_mm_rstn=0.
- i_mm_done seen outside RUN is ignored.

Optional Feature:
MMCTRL_TIMEOUT_EN
- Defined: RUN timeout counter and ABORT state present as above.
- Undefined:
  - No counter; RUN waits for i_mm_done indefinitely.
  - o_err is tied to 0.
  - o_mm_rstn follows only the reset sequencing.

Test Plan:
1. Reset: hold i_rstn=0 5 cycles -> all outputs at reset values; o_mm_rstn=1 exactly 1 cycle after release.
2. Full job, ready always 1:
   - Stimulus: start with fl=3'd5; 128 words 0x00000000..0x0000007F; IP model asserts done 50 cycles after matmul_en.
   - Required: 128 writes at addr 0..127 with matching din; o_mm_fl=5; reads at addr 128..383; 256 output words match the model's SRAM; o_out_last only on word 256; o_busy=0 afterwards.
3. Backpressure: i_out_ready random 30% duty and i_in_valid random 50% -> no lost or duplicated words, output order preserved, output data stable during stalls.
4. Timeout (macro defined): done never asserts -> o_err=1 at cycle 4096 of RUN, o_mm_rstn low 2 cycles, o_busy=0. Next start clears o_err.
5. Start while busy: pulse i_start during LOAD with fl=3'd1 -> ignored, o_mm_fl keeps its original value, word count unchanged.
6. Reset mid-UNLOAD after 10 words: i_rstn=0 1 cycle -> o_out_valid=0, FSM IDLE. A new full job then completes correctly.

Source files
------------

// File: rtl/mm_job_ctrl.sv
// mm_job_ctrl: runs one custom_matmul16x16 job (load operands, run, unload results) over valid/ready streams.
// Optional macro MMCTRL_TIMEOUT_EN adds a RUN watchdog, an ABORT path and the sticky o_err flag.
module mm_job_ctrl #(
    parameter int LD_BASE        = 0,
    parameter int LD_WORDS       = 128,
    parameter int RD_BASE        = 128,
    parameter int RD_WORDS       = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [2:0]  i_fl,
    output logic        o_busy,
    output logic        o_err,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_out_last,
    output logic        o_mm_cen,
    output logic        o_mm_wen,
    output logic [8:0]  o_mm_addr,
    output logic [31:0] o_mm_din,
    input  logic [31:0] i_mm_dout,
    output logic        o_mm_rstn,
    output logic        o_mm_matmul_en,
    output logic [2:0]  o_mm_fl,
    input  logic        i_mm_done
);
    localparam logic [8:0] LD_BASE_A = 9'(LD_BASE);
    localparam logic [8:0] RD_BASE_A = 9'(RD_BASE);
    localparam logic [9:0] LD_LAST   = 10'(LD_WORDS - 1);
    localparam logic [9:0] RD_LAST   = 10'(RD_WORDS - 1);
    localparam logic [9:0] RD_NUM    = 10'(RD_WORDS);

    if (LD_BASE + LD_WORDS > 512 || LD_WORDS < 1) begin : g_bad_ld
        $error("mm_job_ctrl: load region must lie within 512 words");
    end
    if (RD_BASE + RD_WORDS > 512 || RD_WORDS < 1) begin : g_bad_rd
        $error("mm_job_ctrl: result region must lie within 512 words");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("mm_job_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_UNLOAD, ST_ABORT} state_t;

    state_t      state_r;
    logic [9:0]  idx_r;
    logic [9:0]  out_cnt_r;
    logic        busy_r, in_ready_r, out_valid_r, out_last_r;
    logic [31:0] out_data_r;
    logic        mm_cen_r, mm_wen_r, mm_rstn_r, matmul_en_r;
    logic [8:0]  mm_addr_r;
    logic [31:0] mm_din_r;
    logic [2:0]  mm_fl_r;
    logic        rd_issue_r, rd_data_r;
    logic [31:0] fifo_mem_r [2];
    logic        fifo_wp_r, fifo_rp_r;
    logic [1:0]  fifo_occ_r;
    logic        pop_s, out_free_s, fifo_pop_s, push_s, load_s, issue_s, hs_s;
    logic [1:0]  occ_next_s;
    logic [31:0] load_data_s;
`ifdef MMCTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] tcnt_r;
    logic            err_r;
    assign o_err = err_r;
`else
    assign o_err = 1'b0;
`endif

    assign o_busy         = busy_r;
    assign o_in_ready     = in_ready_r;
    assign o_out_valid    = out_valid_r;
    assign o_out_data     = out_data_r;
    assign o_out_last     = out_last_r;
    assign o_mm_cen       = mm_cen_r;
    assign o_mm_wen       = mm_wen_r;
    assign o_mm_addr      = mm_addr_r;
    assign o_mm_din       = mm_din_r;
    assign o_mm_rstn      = mm_rstn_r;
    assign o_mm_matmul_en = matmul_en_r;
    assign o_mm_fl        = mm_fl_r;

    // Output stage steering: the output register refills from the FIFO head, or straight from SRAM data when the FIFO is empty.
    always_comb begin
        pop_s       = out_valid_r & i_out_ready;
        out_free_s  = ~out_valid_r | pop_s;
        fifo_pop_s  = 1'b0;
        push_s      = 1'b0;
        load_s      = 1'b0;
        load_data_s = i_mm_dout;
        if (out_free_s && (fifo_occ_r != 2'd0)) begin
            load_s      = 1'b1;
            fifo_pop_s  = 1'b1;
            load_data_s = fifo_mem_r[fifo_rp_r];
            push_s      = rd_data_r;
        end else if (out_free_s) begin
            load_s = rd_data_r;
        end else begin
            push_s = rd_data_r;
        end
        occ_next_s = fifo_occ_r + {1'b0, push_s} - {1'b0, fifo_pop_s};
        // FIFO entries plus the read still on the SRAM pins must leave room for one more read
        issue_s = (state_r == ST_UNLOAD) && (idx_r < RD_NUM)
                  && (({1'b0, occ_next_s} + {2'b00, rd_issue_r}) < 3'd2);
        hs_s = (state_r == ST_LOAD) && i_in_valid && in_ready_r;
    end

    // Job FSM with registered SRAM/IP pins and the result output stage.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_r       <= ST_IDLE;
            idx_r         <= 10'd0;
            out_cnt_r     <= 10'd0;
            busy_r        <= 1'b0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= 32'd0;
            mm_cen_r      <= 1'b1;
            mm_wen_r      <= 1'b1;
            mm_addr_r     <= 9'd0;
            mm_din_r      <= 32'd0;
            mm_fl_r       <= 3'd0;
            mm_rstn_r     <= 1'b0;
            matmul_en_r   <= 1'b0;
            rd_issue_r    <= 1'b0;
            rd_data_r     <= 1'b0;
            fifo_mem_r[0] <= 32'd0;
            fifo_mem_r[1] <= 32'd0;
            fifo_wp_r     <= 1'b0;
            fifo_rp_r     <= 1'b0;
            fifo_occ_r    <= 2'd0;
`ifdef MMCTRL_TIMEOUT_EN
            tcnt_r        <= '0;
            err_r         <= 1'b0;
`endif
        end else begin
            mm_cen_r   <= 1'b1;
            mm_wen_r   <= 1'b1;
            mm_rstn_r  <= 1'b1;
            rd_issue_r <= 1'b0;
            rd_data_r  <= rd_issue_r;
            if (push_s) begin
                fifo_mem_r[fifo_wp_r] <= i_mm_dout;
                fifo_wp_r             <= ~fifo_wp_r;
            end
            if (fifo_pop_s) begin
                fifo_rp_r <= ~fifo_rp_r;
            end
            fifo_occ_r <= occ_next_s;
            if (load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= load_data_s;
                out_last_r  <= (out_cnt_r == RD_LAST);
                out_cnt_r   <= out_cnt_r + 10'd1;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        mm_fl_r    <= i_fl;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                        idx_r      <= 10'd0;
                        out_cnt_r  <= 10'd0;
                        state_r    <= ST_LOAD;
`ifdef MMCTRL_TIMEOUT_EN
                        err_r      <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        mm_cen_r  <= 1'b0;
                        mm_wen_r  <= 1'b0;
                        mm_addr_r <= LD_BASE_A + idx_r[8:0];
                        mm_din_r  <= i_in_data;
                        if (idx_r == LD_LAST) begin
                            in_ready_r  <= 1'b0;
                            matmul_en_r <= 1'b1;
                            idx_r       <= 10'd0;
                            state_r     <= ST_RUN;
`ifdef MMCTRL_TIMEOUT_EN
                            tcnt_r      <= '0;
`endif
                        end else begin
                            idx_r <= idx_r + 10'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // the first result read is issued on the same edge that leaves RUN
                    if (i_mm_done) begin
                        matmul_en_r <= 1'b0;
                        mm_cen_r    <= 1'b0;
                        mm_addr_r   <= RD_BASE_A;
                        rd_issue_r  <= 1'b1;
                        idx_r       <= 10'd1;
                        state_r     <= ST_UNLOAD;
                    end
`ifdef MMCTRL_TIMEOUT_EN
                    else if (tcnt_r == TO_LAST) begin
                        matmul_en_r <= 1'b0;
                        mm_rstn_r   <= 1'b0;
                        err_r       <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_ABORT;
                    end else begin
                        tcnt_r <= tcnt_r + 1'b1;
                    end
`endif
                end
                ST_UNLOAD: begin
                    if (issue_s) begin
                        mm_cen_r   <= 1'b0;
                        mm_addr_r  <= RD_BASE_A + idx_r[8:0];
                        rd_issue_r <= 1'b1;
                        idx_r      <= idx_r + 10'd1;
                    end
                    if (pop_s && out_last_r) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    mm_rstn_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mm_job_ctrl.sv
// Directed bench for mm_job_ctrl: SRAM/IP model, full jobs, backpressure, timeout, start-while-busy, mid-job reset.
`timescale 1ns/1ps
module tb_mm_job_ctrl;
    logic        clk = 1'b0;
    logic        i_rstn = 1'b0, i_start = 1'b0, i_in_valid = 1'b0, i_out_ready = 1'b0, i_mm_done = 1'b0;
    logic [2:0]  i_fl = 3'd0;
    logic [31:0] i_in_data = 32'd0, i_mm_dout = 32'd0;
    logic        o_busy, o_err, o_in_ready, o_out_valid, o_out_last;
    logic        o_mm_cen, o_mm_wen, o_mm_rstn, o_mm_matmul_en;
    logic [31:0] o_out_data, o_mm_din;
    logic [8:0]  o_mm_addr;
    logic [2:0]  o_mm_fl;

    always #5 clk = ~clk;

    mm_job_ctrl dut (
        .i_clk(clk), .i_rstn(i_rstn), .i_start(i_start), .i_fl(i_fl),
        .o_busy(o_busy), .o_err(o_err),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .o_mm_cen(o_mm_cen), .o_mm_wen(o_mm_wen), .o_mm_addr(o_mm_addr), .o_mm_din(o_mm_din),
        .i_mm_dout(i_mm_dout), .o_mm_rstn(o_mm_rstn), .o_mm_matmul_en(o_mm_matmul_en),
        .o_mm_fl(o_mm_fl), .i_mm_done(i_mm_done)
    );

    int          n_cmp = 0, n_bad = 0;
    int          done_delay = 50;
    logic [31:0] op [128];
    logic [31:0] mem [512];
    int          wr_cnt = 0, rd_cnt = 0, run_cnt = 0;
    logic [8:0]  wr_addr_log [512];
    logic [31:0] wr_din_log [512];
    logic [8:0]  rd_addr_log [512];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_res(input int k);
        return op[k & 127] ^ {16'(k), 16'h5A5A};
    endfunction

    // SRAM and matmul IP model; the IP writes results derived from the stored operands.
    always @(posedge clk) begin
        if (i_start && !o_busy) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end else begin
            if (!o_mm_cen && !o_mm_wen) begin
                mem[o_mm_addr] <= o_mm_din;
                if (wr_cnt < 512) begin
                    wr_addr_log[wr_cnt] <= o_mm_addr;
                    wr_din_log[wr_cnt]  <= o_mm_din;
                end
                wr_cnt <= wr_cnt + 1;
            end
            if (!o_mm_cen && o_mm_wen) begin
                i_mm_dout <= mem[o_mm_addr];
                if (rd_cnt < 512) rd_addr_log[rd_cnt] <= o_mm_addr;
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (!o_mm_matmul_en || !o_mm_rstn) begin
            run_cnt   <= 0;
            i_mm_done <= 1'b0;
        end else begin
            run_cnt <= run_cnt + 1;
            if (run_cnt == done_delay - 1) begin
                i_mm_done <= 1'b1;
                for (int k = 0; k < 256; k++) mem[9'(128 + k)] <= mem[9'(k & 127)] ^ {16'(k), 16'h5A5A};
            end
        end
    end

    task automatic set_ops(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 128; i++) op[i] = base + step * 32'(i);
    endtask

    // mode: 0 normal completion, 1 expect timeout abort, 2 reset after rst_at output words
    task automatic run_job(input logic [2:0] fl, input int vpct, input int rpct, input int pulse_at,
                           input int rst_at, input int mode);
        int in_idx = 0, out_idx = 0, cyc = 0, run_cyc = 0, t_fall = -1, t_first = -1, t_last = -1;
        bit pulsed = 0, prev_stall = 0, saw_en = 0, fin = 0;
        logic [31:0] prev_data = 32'd0;
        logic prev_last = 1'b0;
        @(negedge clk); i_start = 1'b1; i_fl = fl;
        @(negedge clk); i_start = 1'b0; i_fl = 3'd0;
        check_eq("start_busy", 32'(o_busy), 32'd1);
        check_eq("start_fl", 32'(o_mm_fl), 32'(fl));
        check_eq("start_err_clear", 32'(o_err), 32'd0);
        while (!fin && cyc < 12000) begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(o_out_valid), 32'd1);
                check_eq("hold_data", o_out_data, prev_data);
                check_eq("hold_last", 32'(o_out_last), 32'(prev_last));
            end
            if (o_mm_matmul_en) begin saw_en = 1; run_cyc++; end
            else if (saw_en && t_fall < 0) t_fall = cyc;
            if (o_out_valid && t_first < 0) t_first = cyc;
            if (mode == 1 && o_err) begin
                check_eq("abort_run_cycles", 32'(run_cyc), 32'd4096);
                check_eq("abort_busy", 32'(o_busy), 32'd0);
                check_eq("abort_en", 32'(o_mm_matmul_en), 32'd0);
                check_eq("abort_rstn_1", 32'(o_mm_rstn), 32'd0);
                @(negedge clk);
                check_eq("abort_rstn_2", 32'(o_mm_rstn), 32'd0);
                @(negedge clk);
                check_eq("abort_rstn_rel", 32'(o_mm_rstn), 32'd1);
                check_eq("abort_no_out", 32'(out_idx), 32'd0);
                fin = 1;
            end else if (mode == 2 && out_idx == rst_at) begin
                i_rstn = 1'b0; i_out_ready = 1'b0; i_in_valid = 1'b0;
                @(negedge clk);
                check_eq("rst_out_valid", 32'(o_out_valid), 32'd0);
                check_eq("rst_busy", 32'(o_busy), 32'd0);
                check_eq("rst_in_ready", 32'(o_in_ready), 32'd0);
                check_eq("rst_mm_rstn", 32'(o_mm_rstn), 32'd0);
                check_eq("rst_cen", 32'(o_mm_cen), 32'd1);
                i_rstn = 1'b1;
                @(negedge clk);
                check_eq("rst_mm_rstn_rel", 32'(o_mm_rstn), 32'd1);
                fin = 1;
            end else begin
                if (in_idx < 128) begin
                    i_in_valid = (int'($urandom_range(99)) < vpct);
                    i_in_data  = op[in_idx];
                    if (i_in_valid && o_in_ready) in_idx++;
                end else begin
                    i_in_valid = 1'b0;
                end
                if (pulse_at >= 0 && in_idx == pulse_at && !pulsed) begin
                    i_start = 1'b1; i_fl = 3'd1; pulsed = 1;
                end else begin
                    i_start = 1'b0; i_fl = 3'd0;
                end
                i_out_ready = (int'($urandom_range(99)) < rpct);
                prev_stall  = o_out_valid && !i_out_ready;
                prev_data   = o_out_data;
                prev_last   = o_out_last;
                if (o_out_valid && i_out_ready) begin
                    check_eq($sformatf("out_data[%0d]", out_idx), o_out_data, exp_res(out_idx));
                    check_eq($sformatf("out_last[%0d]", out_idx), 32'(o_out_last), 32'(out_idx == 255));
                    t_last = cyc;
                    out_idx++;
                end
                @(negedge clk);
                cyc++;
                if (mode == 0 && out_idx == 256) fin = 1;
            end
        end
        i_out_ready = 1'b0; i_in_valid = 1'b0; i_start = 1'b0;
        check_eq("job_finished", 32'(fin), 32'd1);
        if (mode != 2) begin
            check_eq("wr_count", 32'(wr_cnt), 32'd128);
            for (int i = 0; i < 128; i++) begin
                check_eq($sformatf("wr_addr[%0d]", i), 32'(wr_addr_log[i]), 32'(i));
                check_eq($sformatf("wr_din[%0d]", i), wr_din_log[i], op[i]);
            end
            check_eq("end_busy", 32'(o_busy), 32'd0);
            check_eq("end_fl", 32'(o_mm_fl), 32'(fl));
        end
        if (mode == 0) begin
            check_eq("rd_count", 32'(rd_cnt), 32'd256);
            for (int i = 0; i < 256; i++) check_eq($sformatf("rd_addr[%0d]", i), 32'(rd_addr_log[i]), 32'(128 + i));
            check_eq("end_out_valid", 32'(o_out_valid), 32'd0);
            check_eq("end_err", 32'(o_err), 32'd0);
            if (rpct >= 100) begin
                check_eq("first_latency", 32'(t_first - t_fall), 32'd2);
                check_eq("stream_span", 32'(t_last - t_first + 1), 32'd256);
            end
        end
        if (mode == 1) check_eq("abort_rd_count", 32'(rd_cnt), 32'd0);
    endtask

    initial begin
        // reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_err", 32'(o_err), 32'd0);
        check_eq("rst_in_ready", 32'(o_in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(o_out_valid), 32'd0);
        check_eq("rst_out_last", 32'(o_out_last), 32'd0);
        check_eq("rst_cen", 32'(o_mm_cen), 32'd1);
        check_eq("rst_wen", 32'(o_mm_wen), 32'd1);
        check_eq("rst_addr", 32'(o_mm_addr), 32'd0);
        check_eq("rst_din", o_mm_din, 32'd0);
        check_eq("rst_fl", 32'(o_mm_fl), 32'd0);
        check_eq("rst_en", 32'(o_mm_matmul_en), 32'd0);
        check_eq("rst_mm_rstn", 32'(o_mm_rstn), 32'd0);
        i_rstn = 1'b1;
        @(negedge clk);
        check_eq("rel_mm_rstn", 32'(o_mm_rstn), 32'd1);

        set_ops(32'd0, 32'd1);
        done_delay = 50;
        run_job(3'd5, 100, 100, -1, -1, 0);

        set_ops(32'hC0DE_0100, 32'h0001_0003);
        run_job(3'd2, 50, 30, -1, -1, 0);

`ifdef MMCTRL_TIMEOUT_EN
        set_ops(32'h1234_0000, 32'd7);
        done_delay = 32'h7FFF_FFFF;
        run_job(3'd4, 100, 100, -1, -1, 1);
`else
        set_ops(32'h1234_0000, 32'd7);
        done_delay = 4200;
        run_job(3'd4, 100, 100, -1, -1, 0);
`endif
        done_delay = 50;

        set_ops(32'hA000_0000, 32'd11);
        run_job(3'd6, 100, 100, 40, -1, 0);

        set_ops(32'h5555_0000, 32'd5);
        run_job(3'd3, 100, 100, -1, 10, 2);

        set_ops(32'h0F0F_0000, 32'd13);
        run_job(3'd7, 60, 100, -1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
